// File: rtl/frame_ctr_bank.sv
// ============================================================================
//  Module      : frame_ctr_bank
//  Description : Multi-channel frame counter bank. Each channel counts its
//                enable strobes, wrapping or saturating at 2^WIDTH-1, with a
//                per-channel clear and an atomic snapshot of all channels
//                into shadow registers for host readout.
//
//  Parameters  : WIDTH       counter width in bits (>= 2)
//                CHANNELS    number of independent counters (>= 1)
//                SATURATE    0 = wrap to 0 after max, 1 = hold at max
//                CLR_ON_SNAP 1 = a snapshot also clears the live counters
//                SEL_W       derived select width, max(1, clog2(CHANNELS));
//                            leave at its default
//
//  Ports       : clk        sole clock, rising edge
//                rst        synchronous active-high reset
//                en         per-channel count strobe (+1 per cycle high)
//                clr        per-channel synchronous clear
//                snap       latch all live counters into the shadows
//                rd_sel     shadow channel select
//                rd_data    registered shadow value for rd_sel (0 if out of range)
//                snap_valid one-cycle pulse after shadows are updated
//                count_flat live counters, channel i at [i*WIDTH +: WIDTH]
//                ovf        one-cycle overflow pulse per channel
//                ovf_sticky sticky overflow flags
//
//  Build option: define FRAME_CTR_OVF_STICKY_EN to implement the sticky
//                overflow flags; otherwise ovf_sticky is tied to 0.
//
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module frame_ctr_bank #(
    parameter int WIDTH       = 32,
    parameter int CHANNELS    = 4,
    parameter int SATURATE    = 0,
    parameter int CLR_ON_SNAP = 0,
    parameter int SEL_W       = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [CHANNELS-1:0]       en,
    input  logic [CHANNELS-1:0]       clr,
    input  logic                      snap,
    input  logic [SEL_W-1:0]          rd_sel,
    output logic [WIDTH-1:0]          rd_data,
    output logic                      snap_valid,
    output logic [CHANNELS*WIDTH-1:0] count_flat,
    output logic [CHANNELS-1:0]       ovf,
    output logic [CHANNELS-1:0]       ovf_sticky
);

    localparam logic [WIDTH-1:0] c_max = '1;

    logic                w_snap_clr;
    logic [CHANNELS-1:0] w_ovf_evt;
    logic [WIDTH-1:0]    w_shadow [CHANNELS];
    logic [WIDTH-1:0]    w_rd_mux;

    logic [CHANNELS-1:0] r_ovf;
    logic                r_snap_valid;
    logic [WIDTH-1:0]    r_rd_data;

    // Snapshot-clear only exists when the bank is built to clear on snap.
    assign w_snap_clr = snap & (CLR_ON_SNAP != 0);

    generate
        for (genvar i = 0; i < CHANNELS; i++) begin : g_ch
            logic [WIDTH-1:0] r_count;
            logic [WIDTH-1:0] r_shadow;
            logic             w_at_max;

            assign w_at_max = (r_count == c_max);

            // An overflow is a strobe at max that is not swallowed by a
            // clear or a snapshot-clear in the same cycle. In saturate mode
            // every blocked increment counts as one.
            assign w_ovf_evt[i] = en[i] & w_at_max & ~clr[i] & ~w_snap_clr;

            always_ff @(posedge clk) begin
                if (rst) begin
                    r_count  <= '0;
                    r_shadow <= '0;
                end else begin
                    // Shadow takes the pre-edge value, before any
                    // increment or clear lands.
                    if (snap) begin
                        r_shadow <= r_count;
                    end

                    if (clr[i]) begin
                        r_count <= '0;
                    end else if (w_snap_clr) begin
                        // Keep the strobe that arrives in the snap cycle.
                        r_count <= en[i] ? WIDTH'(1) : '0;
                    end else if (en[i] && !((SATURATE != 0) && w_at_max)) begin
                        r_count <= r_count + WIDTH'(1);
                    end
                end
            end

            assign count_flat[i*WIDTH +: WIDTH] = r_count;
            assign w_shadow[i]                  = r_shadow;
        end
    endgenerate

    // Out-of-range selects fall through to zero.
    always_comb begin
        w_rd_mux = '0;
        for (int k = 0; k < CHANNELS; k++) begin
            if (rd_sel == SEL_W'(k)) begin
                w_rd_mux = w_shadow[k];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf        <= '0;
            r_snap_valid <= 1'b0;
            r_rd_data    <= '0;
        end else begin
            r_ovf        <= w_ovf_evt;
            r_snap_valid <= snap;
            r_rd_data    <= w_rd_mux;
        end
    end

    assign ovf        = r_ovf;
    assign snap_valid = r_snap_valid;
    assign rd_data    = r_rd_data;

`ifdef FRAME_CTR_OVF_STICKY_EN
    logic [CHANNELS-1:0] r_ovf_sticky;

    // Clear beats a same-cycle set; snapshots leave the flags alone.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_ovf_sticky <= '0;
        end else begin
            r_ovf_sticky <= (r_ovf_sticky | w_ovf_evt) & ~clr;
        end
    end

    assign ovf_sticky = r_ovf_sticky;
`else
    assign ovf_sticky = '0;
`endif

endmodule

`default_nettype wire

// File: tb/tb_frame_ctr_bank.sv
// ============================================================================
//  Module      : tb_frame_ctr_bank
//  Description : Scoreboard bench for frame_ctr_bank. Three instances:
//                A = 4 ch, WIDTH 4, wrap, no snapshot-clear
//                B = 4 ch, WIDTH 4, saturate, snapshot-clear
//                C = 3 ch, WIDTH 4, wrap (out-of-range readout)
//                Stimulus queues expected values for a given cycle; a
//                monitor on the falling edge pops and compares them.
//  Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_frame_ctr_bank;

    localparam int S_CNT = 0;
    localparam int S_OVF = 1;
    localparam int S_STK = 2;
    localparam int S_RD  = 3;
    localparam int S_SV  = 4;

    localparam int D_A = 0;
    localparam int D_B = 1;
    localparam int D_C = 2;

`ifdef FRAME_CTR_OVF_STICKY_EN
    localparam logic [31:0] STK_ON = 32'd1;
`else
    localparam logic [31:0] STK_ON = 32'd0;
`endif

    typedef struct {
        int          cyc;
        int          dut;
        int          sig;
        int          ch;
        logic [31:0] val;
        string       name;
    } exp_t;

    logic clk = 1'b0;
    logic rst;
    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    exp_t sb[$];
    logic [31:0] mon_got;

    logic [3:0]  en_a, clr_a, en_b, clr_b;
    logic [2:0]  en_c, clr_c;
    logic        snap_a, snap_b, snap_c;
    logic [1:0]  sel_a, sel_b, sel_c;
    logic [3:0]  rd_a, rd_b, rd_c;
    logic        sv_a, sv_b, sv_c;
    logic [15:0] cnt_a, cnt_b;
    logic [11:0] cnt_c;
    logic [3:0]  ovf_a, stk_a, ovf_b, stk_b;
    logic [2:0]  ovf_c, stk_c;

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    frame_ctr_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(0), .CLR_ON_SNAP(0)) u_a (
        .clk(clk), .rst(rst), .en(en_a), .clr(clr_a), .snap(snap_a), .rd_sel(sel_a),
        .rd_data(rd_a), .snap_valid(sv_a), .count_flat(cnt_a), .ovf(ovf_a), .ovf_sticky(stk_a)
    );

    frame_ctr_bank #(.WIDTH(4), .CHANNELS(4), .SATURATE(1), .CLR_ON_SNAP(1)) u_b (
        .clk(clk), .rst(rst), .en(en_b), .clr(clr_b), .snap(snap_b), .rd_sel(sel_b),
        .rd_data(rd_b), .snap_valid(sv_b), .count_flat(cnt_b), .ovf(ovf_b), .ovf_sticky(stk_b)
    );

    frame_ctr_bank #(.WIDTH(4), .CHANNELS(3), .SATURATE(0), .CLR_ON_SNAP(0)) u_c (
        .clk(clk), .rst(rst), .en(en_c), .clr(clr_c), .snap(snap_c), .rd_sel(sel_c),
        .rd_data(rd_c), .snap_valid(sv_c), .count_flat(cnt_c), .ovf(ovf_c), .ovf_sticky(stk_c)
    );

    function automatic logic [31:0] probe(input int d, input int s, input int ch);
        logic [31:0] r;
        r = '0;
        case (d)
            D_A: case (s)
                S_CNT:   r = 32'(cnt_a[ch*4 +: 4]);
                S_OVF:   r = 32'(ovf_a);
                S_STK:   r = 32'(stk_a);
                S_RD:    r = 32'(rd_a);
                default: r = 32'(sv_a);
            endcase
            D_B: case (s)
                S_CNT:   r = 32'(cnt_b[ch*4 +: 4]);
                S_OVF:   r = 32'(ovf_b);
                S_STK:   r = 32'(stk_b);
                S_RD:    r = 32'(rd_b);
                default: r = 32'(sv_b);
            endcase
            default: case (s)
                S_CNT:   r = 32'(cnt_c[ch*4 +: 4]);
                S_OVF:   r = 32'(ovf_c);
                S_STK:   r = 32'(stk_c);
                S_RD:    r = 32'(rd_c);
                default: r = 32'(sv_c);
            endcase
        endcase
        return r;
    endfunction

    // Monitor: compare every entry due this cycle, flag any that is late.
    always @(negedge clk) begin
        for (int i = sb.size() - 1; i >= 0; i--) begin
            if (sb[i].cyc <= cyc) begin
                mon_got = probe(sb[i].dut, sb[i].sig, sb[i].ch);
                n_cmp++;
                if (sb[i].cyc != cyc || mon_got !== sb[i].val) begin
                    n_bad++;
                    $display("FAIL %s: got %0d, expected %0d (cycle %0d, due %0d)",
                             sb[i].name, mon_got, sb[i].val, cyc, sb[i].cyc);
                end
                sb.delete(i);
            end
        end
    end

    // Expected value of a signal after the next rising edge.
    task automatic ex(input int d, input int s, input int ch, input logic [31:0] v,
                      input string nm);
        exp_t e;
        e.cyc  = cyc + 1;
        e.dut  = d;
        e.sig  = s;
        e.ch   = ch;
        e.val  = v;
        e.name = nm;
        sb.push_back(e);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst = 1'b1;
        en_a = '0; clr_a = '0; snap_a = 1'b0; sel_a = '0;
        en_b = '0; clr_b = '0; snap_b = 1'b0; sel_b = '0;
        en_c = '0; clr_c = '0; snap_c = 1'b0; sel_c = '0;
        tick(); tick();

        // Reset state
        ex(D_A, S_CNT, 0, 0, "init_cnt0");
        ex(D_A, S_RD,  0, 0, "init_rd");
        ex(D_A, S_SV,  0, 0, "init_sv");
        ex(D_A, S_OVF, 0, 0, "init_ovf");
        ex(D_A, S_STK, 0, 0, "init_sticky");
        ex(D_B, S_CNT, 2, 0, "init_b_cnt2");
        tick();
        rst = 1'b0;

        // Reset mid-count with strobes and snap active
        en_a = 4'hF;
        repeat (4) tick();
        snap_a = 1'b1;
        ex(D_A, S_CNT, 0, 5, "pre_rst_cnt0");
        ex(D_A, S_SV,  0, 1, "snap_valid_rise");
        tick();
        snap_a = 1'b0;
        ex(D_A, S_RD,  0, 4, "rd_shadow_pre_edge");
        ex(D_A, S_SV,  0, 0, "snap_valid_fall");
        ex(D_A, S_CNT, 3, 6, "pre_rst_cnt3");
        tick();
        rst = 1'b1; snap_a = 1'b1;
        for (int ch = 0; ch < 4; ch++) ex(D_A, S_CNT, ch, 0, "rst_cnt");
        ex(D_A, S_RD,  0, 0, "rst_rd");
        ex(D_A, S_SV,  0, 0, "rst_sv");
        ex(D_A, S_OVF, 0, 0, "rst_ovf");
        tick();
        rst = 1'b0; en_a = '0; snap_a = 1'b0;

        // Wrap on ch0
        en_a = 4'b0001;
        repeat (14) tick();
        ex(D_A, S_CNT, 0, 15, "wrap_cnt_max");
        ex(D_A, S_OVF, 0, 0,  "wrap_no_early_ovf");
        tick();
        ex(D_A, S_CNT, 0, 0, "wrap_cnt_zero");
        ex(D_A, S_OVF, 0, 1, "wrap_ovf_pulse");
        ex(D_A, S_CNT, 1, 0, "wrap_ch1_idle");
        ex(D_A, S_CNT, 3, 0, "wrap_ch3_idle");
        ex(D_A, S_STK, 0, STK_ON, "wrap_sticky_set");
        tick();
        en_a = '0;
        ex(D_A, S_OVF, 0, 0, "wrap_ovf_single");
        ex(D_A, S_STK, 0, STK_ON, "wrap_sticky_hold");
        tick();

        // Saturate on ch2
        en_b = 4'b0100;
        repeat (14) tick();
        ex(D_B, S_CNT, 2, 15, "sat_reach_max");
        ex(D_B, S_OVF, 0, 0,  "sat_no_early_ovf");
        tick();
        for (int k = 0; k < 3; k++) begin
            ex(D_B, S_CNT, 2, 15, "sat_hold");
            ex(D_B, S_OVF, 0, 4,  "sat_ovf_each");
            tick();
        end
        en_b = '0;
        ex(D_B, S_OVF, 0, 0, "sat_ovf_end");
        ex(D_B, S_STK, 0, STK_ON << 2, "sat_sticky_set");
        tick();
        ex(D_B, S_STK, 0, STK_ON << 2, "sat_sticky_hold");
        tick();
        en_b = 4'b0100; clr_b = 4'b0100;
        ex(D_B, S_CNT, 2, 0, "sat_clr_wins");
        ex(D_B, S_OVF, 0, 0, "sat_clr_blocks_ovf");
        ex(D_B, S_STK, 0, 0, "sat_sticky_clr");
        tick();
        en_b = '0; clr_b = '0;

        // Simultaneous clr/en and snapshot-clear/en
        en_b = 4'b1010;
        repeat (7) tick();
        en_b = 4'b1000;
        tick();
        ex(D_B, S_CNT, 1, 7, "sim_ch1_at7");
        ex(D_B, S_CNT, 3, 9, "sim_ch3_at9");
        tick();
        en_b = 4'b1010; clr_b = 4'b0010; snap_b = 1'b1; sel_b = 2'd3;
        ex(D_B, S_CNT, 1, 0, "sim_clr_over_en");
        ex(D_B, S_CNT, 3, 1, "sim_snapclr_keeps_strobe");
        ex(D_B, S_CNT, 2, 0, "sim_ch2_zero");
        ex(D_B, S_SV,  0, 1, "sim_snap_valid");
        tick();
        en_b = '0; clr_b = '0; snap_b = 1'b0;
        ex(D_B, S_RD,  0, 9, "sim_shadow3");
        ex(D_B, S_SV,  0, 0, "sim_snap_valid_end");
        ex(D_B, S_CNT, 3, 1, "sim_live3");
        tick();
        sel_b = 2'd1;
        ex(D_B, S_RD, 0, 7, "sim_shadow1_pre_clr");
        tick();

        // Snapshot-clear at max suppresses the overflow
        en_b = 4'b0001; sel_b = 2'd0;
        repeat (15) tick();
        snap_b = 1'b1;
        ex(D_B, S_CNT, 0, 1, "snapclr_at_max");
        ex(D_B, S_OVF, 0, 0, "snapclr_no_ovf");
        tick();
        en_b = '0; snap_b = 1'b0;
        ex(D_B, S_RD, 0, 15, "snapclr_shadow_max");
        tick();

        // Readout sweep: counts {3,5,7,9}
        clr_a = 4'hF;
        ex(D_A, S_STK, 0, 0, "clr_sticky_a");
        tick();
        clr_a = '0;
        for (int k = 0; k < 9; k++) begin
            en_a = {k < 9, k < 7, k < 5, k < 3};
            tick();
        end
        en_a = '0; snap_a = 1'b1; sel_a = 2'd0;
        ex(D_A, S_CNT, 0, 3, "nosnapclr_cnt0");
        ex(D_A, S_CNT, 3, 9, "nosnapclr_cnt3");
        tick();
        snap_a = 1'b0;
        for (int i = 0; i < 4; i++) begin
            sel_a = 2'(i);
            ex(D_A, S_RD, 0, 32'(3 + 2 * i), "rd_sweep");
            tick();
        end

        // Three-channel bank, out-of-range select
        en_c = 3'b111;
        repeat (2) tick();
        en_c = '0; snap_c = 1'b1;
        tick();
        snap_c = 1'b0; sel_c = 2'd2;
        ex(D_C, S_RD, 0, 2, "c3_rd_ch2");
        tick();
        sel_c = 2'd3;
        ex(D_C, S_RD, 0, 0, "c3_rd_out_of_range");
        tick();
        sel_c = 2'd0;
        ex(D_C, S_RD, 0, 2, "c3_rd_ch0");
        tick();

        // Back-to-back snapshots while ch0 counts (ch0 starts at 3)
        en_a = 4'b0001; snap_a = 1'b1; sel_a = 2'd0;
        ex(D_A, S_SV,  0, 1, "b2b_sv1");
        ex(D_A, S_CNT, 0, 4, "b2b_cnt1");
        tick();
        ex(D_A, S_SV, 0, 1, "b2b_sv2");
        ex(D_A, S_RD, 0, 3, "b2b_rd2");
        tick();
        ex(D_A, S_SV,  0, 1, "b2b_sv3");
        ex(D_A, S_RD,  0, 4, "b2b_rd3");
        ex(D_A, S_CNT, 0, 6, "b2b_cnt3");
        tick();
        en_a = '0; snap_a = 1'b0;
        ex(D_A, S_SV, 0, 0, "b2b_sv_end");
        ex(D_A, S_RD, 0, 5, "b2b_rd4");
        tick();

        for (int k = 0; k < 20 && sb.size() > 0; k++) tick();
        if (sb.size() > 0) begin
            n_cmp++;
            n_bad++;
            $display("FAIL scoreboard_drain: %0d entries pending, expected 0", sb.size());
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

`default_nettype wire

// File: doc/frame_ctr_bank.md
# frame_ctr_bank

Multi-channel, parametrised frame counter bank. Counts per-channel enable strobes (one frame event per strobe) with selectable wrap or saturate behaviour, per-channel clear, and an atomic snapshot of all channels into shadow registers for readout by the host-side register interface. It sits between the frame-generation logic and the Xillybus-facing status path, and replaces single free-running 32-bit frame counters.

## Interface
- `WIDTH`, 32: counter width in bits (≥2).
- `CHANNELS`, 4: number of independent counters (≥1).
- `SATURATE`, 0: 0 = wrap at 2^WIDTH−1 → 0; 1 = hold at 2^WIDTH−1.
- `CLR_ON_SNAP`, 0: 1 = snapshot also clears live counters.
- `SEL_W`, derived: max(1, clog2(CHANNELS)).

- `clk`  in  1  sole clock; all logic on rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `en`  in  CHANNELS  per-channel count strobe; +1 per cycle high.
- `clr`  in  CHANNELS  per-channel synchronous clear.
- `snap`  in  1  latch all live counters into shadow registers.
- `rd_sel`  in  SEL_W  shadow channel select.
- `rd_data`  out  WIDTH  registered shadow value for `rd_sel`.
- `snap_valid`  out  1  one-cycle pulse: shadows updated.
- `count_flat`  out  CHANNELS×WIDTH  live counters, channel i at bits [i×WIDTH +: WIDTH].
- `ovf`  out  CHANNELS  one-cycle overflow pulse per channel.
- `ovf_sticky`  out  CHANNELS  sticky overflow flags (see Configuration).

## Operation
- Reset: all live counters, shadows, `rd_data`, `snap_valid`, `ovf`, `ovf_sticky` = 0. Reset overrides every other input.
- Per channel i, priority per cycle: `rst` > `clr[i]` > snapshot-clear > `en[i]`.
  - `clr[i]`: count ← 0, regardless of `en[i]`.
  - `snap` with `CLR_ON_SNAP`=1 and no `clr[i]`: count ← 1 if `en[i]` else 0 (the strobe in the snap cycle is not lost).
  - `en[i]` only: count ← count+1 (mod 2^WIDTH) if `SATURATE`=0; if `SATURATE`=1 and count = max, count holds.
- Overflow event for channel i: `en[i]` high, count = 2^WIDTH−1, no `clr[i]`, no snapshot-clear. Both modes register `ovf[i]`=1 for the next cycle; in saturate mode every blocked increment at max raises a pulse.
- Snapshot: shadow[i] ← live count[i] as of before the edge (pre-increment, pre-clear), all channels same edge.
- Readout: `rd_data` ← shadow[`rd_sel`]; `rd_sel` ≥ CHANNELS returns 0.
- No handshake back-pressure; `snap` may be asserted every cycle.

## Timing
- `count_flat`: updated the edge after `en`/`clr`/`snap`; latency 1.
- `ovf[i]`: high exactly one cycle, the cycle after the overflow edge.
- `snap_valid`: high the cycle after `snap` sampled; back-to-back `snap` keeps it high.
- `rd_data`: 1-cycle latency from `rd_sel` change or shadow update; `snap` at edge N with fixed `rd_sel` yields the new value at cycle N+2... precisely, shadow valid after edge N, `rd_data` valid after edge N+1.
- Reset mid-count: next cycle all outputs 0; strobes in the reset cycle are dropped.

## Configuration
- `FRAME_CTR_OVF_STICKY_EN` defined: `ovf_sticky[i]` set on the edge of a channel-i overflow event, held until `rst` or `clr[i]` (`clr[i]` wins over a same-cycle set; snapshot does not clear it).
- Not defined: `ovf_sticky` tied to 0, no sticky registers synthesised; all other behaviour identical.

## Test plan
- Reset: drive `en`=all-ones 5 cycles, assert `rst` 1 cycle with `en` high → all `count_flat` fields, `rd_data`, `ovf`, `snap_valid` = 0 next cycle.
- Wrap (WIDTH=4, SATURATE=0): 16 strobes on ch0 → count 15→0, `ovf[0]` single pulse, ch1–3 stay 0.
- Saturate (WIDTH=4, SATURATE=1): 18 strobes on ch2 → count holds 15, `ovf[2]` pulses on each of last 3 strobes; with macro, `ovf_sticky[2]`=1 until `clr[2]`.
- Simultaneous: ch1 at 7, `en[1]`+`clr[1]` same cycle → 0; ch3 at 9, `en[3]`+`snap` with CLR_ON_SNAP=1 → shadow[3]=9, live=1, `snap_valid` pulse.
- Readout: after snap with counts {3,5,7,9}, sweep `rd_sel` 0..3 → `rd_data` 3,5,7,9 one cycle later; CHANNELS=3, `rd_sel`=3 → 0.
- Back-to-back `snap` 3 cycles with ch0 counting → shadow[0] tracks pre-edge count each cycle, `snap_valid` high 3 cycles.
